// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver with a small byte FIFO on the output.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   rx_i         - serial line, idle high, async to clk
//   data_o       - byte at FIFO head (00 when empty)
//   valid_o      - FIFO non-empty
//   ready_i      - consumer pops head when valid_o && ready_i
//   frame_err_o  - one-cycle pulse on a low stop bit
//   overrun_o    - one-cycle pulse when a byte is dropped on a full FIFO
module uart_rx_unit #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Timer runs from 0 after each sample point, so the
  // terminal value is one less than the interval.
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state;
  logic            sync1;
  logic            rx_s;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            push;
  logic            pop;
  logic            full;
  logic            wr_en;

  // Two-flop synchronizer; resets to the idle level so
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer   <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_HIGH: begin
          // Hold here through a break so it reports once.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push is taken straight from the stop-sample decision so
  // the byte lands in the FIFO on the same edge.
  assign push  = (state == STOP) && (timer == T_FULL) && rx_s;
  assign pop   = valid_o && ready_i;
  assign full  = (count == C_FULL);
  // On a full FIFO a concurrent pop frees the slot that
  // wr_ptr (== rd_ptr) addresses, so the write is safe.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= push && full && !pop;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_en && !pop) begin
        count <= count + CW'(1);
      end else if (!wr_en && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign valid_o = (count != '0);
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: directed and randomized frames checked
// against a byte-queue scoreboard and event counters.
module tb_uart_rx_unit;

  localparam int C = 16;
  localparam int D = 4;
  // rx_i edge -> stop-sample edge: 1 edge to reach the first
  // flop, 2 more to detect in IDLE, then half a bit plus nine bits.
  localparam int LAT = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [7:0] exp_q [$];

  int vhigh = 0;
  int vrise = 0;
  int fe_cnt = 0;
  int ovr_cnt = 0;
  int fe_cyc = 0;
  int ovr_cyc = 0;
  int vrise_cyc = 0;
  int fall_cyc = 0;

  logic       prev_valid = 1'b0;
  logic       prev_pop = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       rdone = 1'b0;

  uart_rx_unit #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic sb);
    logic [9:0] f;
    f = {sb, b, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      repeat (C) tick();
    end
  endtask

  // Observer on the falling edge, away from the launch edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) vhigh++;
      if (valid_o && !prev_valid) begin
        vrise++;
        vrise_cyc = cyc;
      end
      if (frame_err_o) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (overrun_o) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
      if (valid_o && prev_valid && !prev_pop)
        chk("hold", data_o, prev_data);
      if (valid_o && ready_i) begin
        chk("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("data", data_o, exp_q.pop_front());
      end
    end
    prev_valid = valid_o;
    prev_pop   = valid_o && ready_i;
    prev_data  = data_o;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int vh, vr, fe, ov;
    logic [7:0] b;
    logic [9:0] pf;

    rst_n   = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    rst_n = 1'b1;
    repeat (10) tick();

    // Single frame, consumer always ready.
    ready_i = 1'b1;
    vh = vhigh; fe = fe_cnt; ov = ovr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (20) tick();
    chk("a5_vhigh", vhigh - vh, 1);
    chk("a5_lat", vrise_cyc - fall_cyc, LAT);
    chk("a5_ferr", fe_cnt - fe, 0);
    chk("a5_ovr", ovr_cnt - ov, 0);
    chk("a5_drain", exp_q.size(), 0);

    // Short low glitch is rejected.
    vr = vrise; fe = fe_cnt; ov = ovr_cnt;
    rx_i = 1'b0;
    repeat (4) tick();
    rx_i = 1'b1;
    repeat (30) tick();
    chk("gl_valid", vrise - vr, 0);
    chk("gl_ferr", fe_cnt - fe, 0);
    chk("gl_ovr", ovr_cnt - ov, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (20) tick();
    chk("3c_rise", vrise - vr, 1);
    chk("3c_drain", exp_q.size(), 0);

    // Bad stop bit followed by a held-low break.
    vr = vrise; fe = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (40) tick();
    rx_i = 1'b1;
    repeat (20) tick();
    chk("brk_ferr", fe_cnt - fe, 1);
    chk("brk_lat", fe_cyc - fall_cyc, LAT);
    chk("brk_valid", vrise - vr, 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    repeat (20) tick();
    chk("0f_rise", vrise - vr, 1);
    chk("0f_drain", exp_q.size(), 0);

    // Five back-to-back frames into a four-deep FIFO.
    ready_i = 1'b0;
    ov = ovr_cnt;
    for (int k = 1; k <= 5; k++) begin
      if (k <= D) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1);
    end
    repeat (20) tick();
    chk("ovr_cnt", ovr_cnt - ov, 1);
    chk("ovr_lat", ovr_cyc - fall_cyc, LAT);
    chk("ovr_valid", valid_o, 1);
    chk("ovr_head", data_o, exp_q[0]);
    ready_i = 1'b1;
    repeat (D - 1) tick();
    chk("ovr_last", valid_o, 1);
    tick();
    chk("ovr_empty", valid_o, 0);
    chk("ovr_drain", exp_q.size(), 0);

    // Full FIFO with a pop on the stop-sample edge.
    ready_i = 1'b0;
    ov = ovr_cnt;
    for (int k = 0; k < D; k++) begin
      exp_q.push_back(8'h11 + 8'(k));
      send_frame(8'h11 + 8'(k), 1'b1);
    end
    repeat (5) tick();
    exp_q.push_back(8'h11 + 8'(D));
    fork
      send_frame(8'h11 + 8'(D), 1'b1);
      begin
        repeat (LAT - 1) tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
      end
    join
    repeat (10) tick();
    chk("fp_ovr", ovr_cnt - ov, 0);
    chk("fp_valid", valid_o, 1);
    ready_i = 1'b1;
    repeat (D + 2) tick();
    chk("fp_drain", exp_q.size(), 0);
    chk("fp_empty", valid_o, 0);

    // Reset in the middle of bit 3.
    ready_i = 1'b0;
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    repeat (5) tick();
    chk("pre_valid", valid_o, 1);
    chk("pre_data", data_o, 8'h77);
    pf = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx_i = pf[i];
      repeat (C) tick();
    end
    rx_i = pf[4];
    repeat (C / 2) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", valid_o, 0);
    chk("mrst_data", data_o, 0);
    chk("mrst_ferr", frame_err_o, 0);
    chk("mrst_ovr", overrun_o, 0);
    exp_q.delete();
    rx_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    vr = vrise; fe = fe_cnt; ov = ovr_cnt;
    ready_i = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (20) tick();
    chk("c3_rise", vrise - vr, 1);
    chk("c3_drain", exp_q.size(), 0);
    chk("c3_ferr", fe_cnt - fe, 0);
    chk("c3_ovr", ovr_cnt - ov, 0);

    // Random bytes, gaps and consumer back-pressure.
    fe = fe_cnt; ov = ovr_cnt;
    rdone = 1'b0;
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          b = 8'($urandom);
          exp_q.push_back(b);
          send_frame(b, 1'b1);
          repeat ($urandom_range(0, 3 * C)) tick();
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          ready_i = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    ready_i = 1'b1;
    repeat (20) tick();
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_ferr", fe_cnt - fe, 0);
    chk("rnd_ovr", ovr_cnt - ov, 0);
    chk("rnd_empty", valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
